cluster_clock_gate_ctrl: RTL and testbench
==========================================

# cluster_clock_gate_ctrl

Multi-channel automatic clock-gate controller for the cluster. Each of `NUM_CH` channels gates its own clock branch through one integrated clock-gating cell. A per-channel FSM closes the gate after a programmable number of consecutive idle cycles. On a busy request it reopens the gate and acknowledges with `ready_o` after a fixed wake-up settle time. It sits between the cluster power/event logic and the per-peripheral clock branches.

## Interface
- `NUM_CH`, 4: number of gated channels (1–32).
- `IDLE_W`, 8: width of the idle counter and of `idle_thresh_i`.
- `WAKE_CYC`, 2: cycles between gate reopening and `ready_o` (0–15).
- `STAT_W`, 16: width of each gated-cycle statistics counter.

Ports:
- `clk_i`  in  1  cluster clock; ungated source for all channels.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `test_en_i`  in  1  scan/test enable; forces every `gclk_o` to run.
- `busy_i`  in  NUM_CH  per-channel activity request.
- `force_on_i`  in  NUM_CH  per-channel software override; keeps the channel ungated.
- `idle_thresh_i`  in  IDLE_W  shared idle threshold T.
- `stats_clr_i`  in  1  synchronous clear of all statistics counters.
- `gclk_o`  out  NUM_CH  gated clock per channel.
- `clk_en_o`  out  NUM_CH  registered gate enable per channel.
- `ready_o`  out  NUM_CH  channel clock is stable and usable.
- `all_idle_o`  out  1  high when every channel is in OFF.
- `gated_cnt_o`  out  NUM_CH*STAT_W  gated-cycle count per channel; channel i occupies bits [i*STAT_W +: STAT_W].

## Operation
- Per channel: one FSM, one IDLE_W-bit idle counter and one 4-bit wake counter.
- Each channel has one ICG cell: `gclk_o[i] = ICG(clk_i, EN=clk_en_o[i], SE=test_en_i)`.
- Each ICG cell is a latch-based gate, transparent while `clk_i` is low, so it is glitch-free.
- `act = busy_i[i] | force_on_i[i]`.
- FSM states and behaviour:
  - ON: `clk_en_o=1`, `ready_o=1`.
    - If `act`: `idle_cnt` is cleared to 0.
    - Else if `idle_cnt >= idle_thresh_i`: go to OFF.
    - Else: `idle_cnt` increments, saturating.
  - OFF: `clk_en_o=0`, `ready_o=0`.
    - If `act`: go to WAKE and load `wake_cnt=WAKE_CYC`.
    - If `WAKE_CYC==0`: go directly to ON instead.
  - WAKE: `clk_en_o=1`, `ready_o=0`.
    - `wake_cnt` decrements each cycle.
    - When it reaches 0: go to ON with `idle_cnt=0`.
    - WAKE always completes, even if `act` drops.
- `clk_en_o` and `ready_o` are decoded from registered state only, so they are glitch-free.
- Simultaneous events:
  - `act` and threshold reached in the same cycle: `act` wins and the channel stays ON.
  - `idle_thresh_i` lowered below the current `idle_cnt`: the `>=` compare gates the channel on the next idle cycle.
- `all_idle_o`: registered AND over the per-channel OFF states.
- `test_en_i` does not alter FSM state, `clk_en_o` or `ready_o`; it acts on the ICG SE input only.
- Reset (asynchronous, mid-operation included): all channels enter ON.
  - `clk_en_o` is all ones; `ready_o` is all ones.
  - `all_idle_o=0`; `idle_cnt=0`; `wake_cnt=0`; `gated_cnt_o=0`.
  - Gated domains therefore receive clock while reset deasserts.

## Timing
- Gate close: with threshold T, `clk_en_o` and `ready_o` fall on the edge that samples the (T+1)-th consecutive idle cycle.
- Wake-up:
  - `act` sampled in OFF at edge k: `clk_en_o` rises after edge k.
  - `ready_o` rises after edge k+WAKE_CYC.
  - `gclk_o` first rising edge is at edge k+1.
- Handshake: the requester holds `busy_i` until it sees `ready_o=1`. A `busy_i` pulse of one cycle still completes a full wake and returns to ON.
- All outputs are registered except `gclk_o`; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CLK_GATE_STATS_EN`.
- Defined:
  - Per channel, an STAT_W-bit saturating counter increments every cycle `clk_en_o[i]==0`.
  - `stats_clr_i` clears all counters on the next edge and takes priority over increment.
- Undefined:
  - No counters are built.
  - `gated_cnt_o` is tied to 0 and `stats_clr_i` is ignored.
  - Port list is unchanged.

## Test plan
- Reset state:
  - Stimulus: assert `rst_ni=0` mid-WAKE on channel 1.
  - Required: all `clk_en_o=4'hF`, `ready_o=4'hF`, `all_idle_o=0` immediately, with no clock edge needed.
- Idle close:
  - Stimulus: T=3, `busy_i[0]` low from edge 0.
  - Required: `clk_en_o[0]` and `ready_o[0]` fall after edge 3; `gclk_o[0]` stays low from then on.
- Wake:
  - Stimulus: `WAKE_CYC=2`, channel 0 OFF, `busy_i[0]` pulses for one cycle at edge 10.
  - Required: `clk_en_o[0]=1` after edge 10; `ready_o[0]=1` after edge 12; gate closes again after T+1 further idle cycles.
- Priority:
  - Stimulus: `busy_i` asserted exactly in the threshold cycle.
  - Required: the channel stays ON and `idle_cnt` returns to 0.
  - Stimulus: `force_on_i[2]=1` with `busy_i` low for 300 cycles.
  - Required: channel 2 is never gated.
- Test mode and all-idle:
  - Stimulus: all four channels OFF.
  - Required: `all_idle_o=1`.
  - Stimulus: then `test_en_i=1`.
  - Required: all `gclk_o` toggle, `clk_en_o` stays 0, and `ready_o` stays 0.
- Stats (`CLK_GATE_STATS_EN` defined):
  - Stimulus: channel 3 OFF for 50 cycles.
  - Required: `gated_cnt_o[3]=50`.
  - Stimulus: `stats_clr_i=1` together with a gated cycle.
  - Required: count reads 0 on the next edge.
  - Required: with the macro undefined, the count reads 0 at all times.

Source files
------------

// File: rtl/cluster_clock_gate_ctrl.sv
// ----------------------------------------------------------------------------
// cluster_clock_gate_ctrl: per-channel idle-driven ICG controller with wake
// handshake; optional gated-cycle statistics under CLK_GATE_STATS_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cluster_clock_gate_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2,
  parameter int STAT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     test_en_i,
  input  logic [NUM_CH-1:0]        busy_i,
  input  logic [NUM_CH-1:0]        force_on_i,
  input  logic [IDLE_W-1:0]        idle_thresh_i,
  input  logic                     stats_clr_i,
  output logic [NUM_CH-1:0]        gclk_o,
  output logic [NUM_CH-1:0]        clk_en_o,
  output logic [NUM_CH-1:0]        ready_o,
  output logic                     all_idle_o,
  output logic [NUM_CH*STAT_W-1:0] gated_cnt_o
);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_e;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYC);

  logic [NUM_CH-1:0] off_d;
  logic              all_idle_q;

`ifndef CLK_GATE_STATS_EN
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]        wake_cnt_q, wake_cnt_d;
    logic              clk_en_q, clk_en_d;
    logic              ready_q, ready_d;
    logic              act;
    logic              en_lat;

    assign act = busy_i[i] | force_on_i[i];

    always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      case (state_q)
        ST_ON: begin
          // Activity takes priority over reaching the threshold.
          if (act) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q >= idle_thresh_i) begin
            state_d = ST_OFF;
          end else if (idle_cnt_q != {IDLE_W{1'b1}}) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        ST_OFF: begin
          if (act) begin
            if (WAKE_CYC == 0) begin
              state_d    = ST_ON;
              idle_cnt_d = '0;
            end else begin
              state_d    = ST_WAKE;
              wake_cnt_d = WAKE_LOAD;
            end
          end
        end
        ST_WAKE: begin
          // Wake runs to completion regardless of act.
          if (wake_cnt_q <= 4'd1) begin
            state_d    = ST_ON;
            wake_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            wake_cnt_d = wake_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d    = ST_ON;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end
      endcase
      clk_en_d = (state_d != ST_OFF);
      ready_d  = (state_d == ST_ON);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= ST_ON;
        idle_cnt_q <= '0;
        wake_cnt_q <= '0;
        clk_en_q   <= 1'b1;
        ready_q    <= 1'b1;
      end else begin
        state_q    <= state_d;
        idle_cnt_q <= idle_cnt_d;
        wake_cnt_q <= wake_cnt_d;
        clk_en_q   <= clk_en_d;
        ready_q    <= ready_d;
      end
    end

    assign off_d[i]    = (state_d == ST_OFF);
    assign clk_en_o[i] = clk_en_q;
    assign ready_o[i]  = ready_q;

    // Enable latch is transparent while clk_i is low, so gclk cannot glitch.
    always_latch begin
      if (!clk_i) begin
        en_lat <= clk_en_q | test_en_i;
      end
    end

    assign gclk_o[i] = clk_i & en_lat;

`ifdef CLK_GATE_STATS_EN
    logic [STAT_W-1:0] gated_cnt_q, gated_cnt_d;

    always_comb begin
      gated_cnt_d = gated_cnt_q;
      if (stats_clr_i) begin
        gated_cnt_d = '0;
      end else if (!clk_en_q && (gated_cnt_q != {STAT_W{1'b1}})) begin
        gated_cnt_d = gated_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        gated_cnt_q <= '0;
      end else begin
        gated_cnt_q <= gated_cnt_d;
      end
    end

    assign gated_cnt_o[i*STAT_W +: STAT_W] = gated_cnt_q;
`else
    assign gated_cnt_o[i*STAT_W +: STAT_W] = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      all_idle_q <= 1'b0;
    end else begin
      all_idle_q <= &off_d;
    end
  end

  assign all_idle_o = all_idle_q;

endmodule

`default_nettype wire

// File: tb/tb_cluster_clock_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cluster_clock_gate_ctrl: scoreboard bench for cluster_clock_gate_ctrl.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cluster_clock_gate_ctrl;

  localparam int NCH  = 4;
  localparam int WAKE = 2;
  localparam int M_ON = 0, M_OFF = 1, M_WAKE = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        test_en_i = 1'b0;
  logic [3:0]  busy_i = 4'h0;
  logic [3:0]  force_on_i = 4'h0;
  logic [7:0]  idle_thresh_i = 8'd3;
  logic        stats_clr_i = 1'b0;
  logic [3:0]  gclk_o;
  logic [3:0]  clk_en_o;
  logic [3:0]  ready_o;
  logic        all_idle_o;
  logic [63:0] gated_cnt_o;

  cluster_clock_gate_ctrl #(
    .NUM_CH(NCH), .IDLE_W(8), .WAKE_CYC(WAKE), .STAT_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .test_en_i(test_en_i), .busy_i(busy_i),
    .force_on_i(force_on_i), .idle_thresh_i(idle_thresh_i),
    .stats_clr_i(stats_clr_i), .gclk_o(gclk_o), .clk_en_o(clk_en_o),
    .ready_o(ready_o), .all_idle_o(all_idle_o), .gated_cnt_o(gated_cnt_o)
  );

  always #5 clk = ~clk;

  int gcnt0 = 0, gcnt1 = 0, gcnt2 = 0, gcnt3 = 0;
  always @(posedge gclk_o[0]) gcnt0++;
  always @(posedge gclk_o[1]) gcnt1++;
  always @(posedge gclk_o[2]) gcnt2++;
  always @(posedge gclk_o[3]) gcnt3++;

  int n_chk = 0, n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  rdy;
    logic        idle;
    logic [63:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: tracks consecutive idle cycles seen while ON.
  int          mode [NCH];
  int          run  [NCH];
  int          wk   [NCH];
  logic [15:0] mcnt [NCH];
  logic [3:0]  men;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = M_ON; run[c] = 0; wk[c] = 0; mcnt[c] = 16'd0;
    end
    men = 4'hF;
  endtask

  task automatic model_step();
    exp_t e;
    bit   a;
    e.idle = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (stats_clr_i) mcnt[c] = 16'd0;
      else if (!men[c] && mcnt[c] != 16'hFFFF) mcnt[c] = mcnt[c] + 16'd1;
      a = busy_i[c] | force_on_i[c];
      if (mode[c] == M_ON) begin
        if (a) run[c] = 0;
        else begin
          run[c]++;
          if (run[c] > int'(idle_thresh_i)) mode[c] = M_OFF;
        end
      end else if (mode[c] == M_OFF) begin
        if (a) begin
          if (WAKE == 0) begin mode[c] = M_ON; run[c] = 0; end
          else begin mode[c] = M_WAKE; wk[c] = WAKE; end
        end
      end else begin
        wk[c]--;
        if (wk[c] == 0) begin mode[c] = M_ON; run[c] = 0; end
      end
      men[c]   = (mode[c] != M_OFF);
      e.en[c]  = (mode[c] != M_OFF);
      e.rdy[c] = (mode[c] == M_ON);
      if (mode[c] != M_OFF) e.idle = 1'b0;
    end
`ifdef CLK_GATE_STATS_EN
    e.cnt = {mcnt[3], mcnt[2], mcnt[1], mcnt[0]};
`else
    e.cnt = 64'd0;
`endif
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_val("clk_en", {60'd0, clk_en_o}, {60'd0, mon_e.en});
      check_val("ready", {60'd0, ready_o}, {60'd0, mon_e.rdy});
      check_val("all_idle", {63'd0, all_idle_o}, {63'd0, mon_e.idle});
      check_val("gated_cnt", gated_cnt_o, mon_e.cnt);
    end
  end

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_en"}, {60'd0, clk_en_o}, 64'hF);
    check_val({tag, "_rdy"}, {60'd0, ready_o}, 64'hF);
    check_val({tag, "_idle"}, {63'd0, all_idle_o}, 64'd0);
    check_val({tag, "_cnt"}, gated_cnt_o, 64'd0);
  endtask

  int s0, s1, s2, s3;

  initial begin
    busy_i = 4'b1110;
    #1 rst_ni = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    model_reset();

    // Idle close on channel 0 with T=3, then gclk[0] must stay quiet.
    cycle(4);
    check_val("ch0_closed", {63'd0, clk_en_o[0]}, 64'd0);
    s0 = gcnt0; s1 = gcnt1;
    cycle(10);
    check_val("gclk0_off", 64'(gcnt0 - s0), 64'd0);
    check_val("gclk1_on", 64'(gcnt1 - s1), 64'd10);

    // One-cycle busy pulse completes a full wake, then closes after T+1 idles.
    busy_i[0] = 1'b1; cycle(1); busy_i[0] = 1'b0;
    check_val("wake_en", {63'd0, clk_en_o[0]}, 64'd1);
    check_val("wake_rdy", {63'd0, ready_o[0]}, 64'd0);
    cycle(10);

    // busy in the threshold cycle keeps ch1 ON and restarts the idle count.
    busy_i[1] = 1'b0; cycle(3);
    busy_i[1] = 1'b1; cycle(1);
    busy_i[1] = 1'b0; cycle(3);
    check_val("prio_rdy", {63'd0, ready_o[1]}, 64'd1);
    cycle(1);
    check_val("prio_closed", {63'd0, clk_en_o[1]}, 64'd0);

    // force_on keeps channel 2 running for 300 idle cycles.
    force_on_i[2] = 1'b1; busy_i[2] = 1'b0;
    s2 = gcnt2;
    cycle(300);
    check_val("force_gclk2", 64'(gcnt2 - s2), 64'd300);
    force_on_i[2] = 1'b0;
    cycle(4);

    // Channel 3 goes idle; all channels OFF, then 50 gated cycles.
    busy_i[3] = 1'b0;
    cycle(4);
    cycle(50);
    check_val("all_idle", {63'd0, all_idle_o}, 64'd1);

    // Test mode runs every gclk without touching enables or ready.
    test_en_i = 1'b1;
    s0 = gcnt0; s1 = gcnt1; s2 = gcnt2; s3 = gcnt3;
    cycle(10);
    check_val("tm_gclk0", 64'(gcnt0 - s0), 64'd10);
    check_val("tm_gclk1", 64'(gcnt1 - s1), 64'd10);
    check_val("tm_gclk2", 64'(gcnt2 - s2), 64'd10);
    check_val("tm_gclk3", 64'(gcnt3 - s3), 64'd10);
    test_en_i = 1'b0;

    // Clear coincident with a gated cycle wins over the increment.
    stats_clr_i = 1'b1; cycle(1); stats_clr_i = 1'b0;
    check_val("clr_cnt", gated_cnt_o, 64'd0);
    cycle(3);

    // Threshold lowered below the running idle count closes on the next idle.
    idle_thresh_i = 8'd8;
    busy_i[0] = 1'b1; cycle(1); busy_i[0] = 1'b0;
    cycle(2);
    cycle(5);
    idle_thresh_i = 8'd2;
    cycle(1);
    check_val("thr_lower", {63'd0, clk_en_o[0]}, 64'd0);
    idle_thresh_i = 8'd3;

    // Asynchronous reset in the middle of a wake on channel 1.
    busy_i[1] = 1'b1; cycle(1); busy_i[1] = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    cycle(6);

    @(posedge clk); #2;
    check_val("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
